// File: rtl/reg_file_32x32.sv
// ============================================================================
//  Module   : reg_file_32x32
//  Purpose  : 32-entry register file with one-hot write select, two
//             write-through read ports and a sticky one-hot error flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_32x32 #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       load,
   input  logic              we,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [4:0]        rs_a,
   input  logic [4:0]        rs_b,
   output logic [DATA_W-1:0] rd_a,
   output logic [DATA_W-1:0] rd_b,
   input  logic              err_clr,
   output logic              load_err
);

   logic [DATA_W-1:0] regs_q [32];
   logic [DATA_W-1:0] regs_d [32];
   logic              load_err_q;
   logic              load_err_d;

   logic              w_onehot;
   logic              w_wr_valid;
   logic              w_wr_bad;
   logic              w_bypass_en;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   assign w_onehot    = (load != 32'd0) && ((load & (load - 32'd1)) == 32'd0);
   assign w_wr_valid  = we && w_onehot;
   assign w_wr_bad    = we && !w_onehot;
   assign w_bypass_en = rst_n && w_wr_valid;

   always_comb begin
      regs_d = regs_q;
      if (w_wr_valid) begin
         for (int i = 1; i < 32; i++) begin
            if (load[i]) begin
               regs_d[i] = wr_data;
            end
         end
      end
      regs_d[0] = '0;
   end

   always_comb begin
      load_err_d = load_err_q;
      if (w_wr_bad) begin
         load_err_d = 1'b1;
      end else if (err_clr) begin
         load_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
         load_err_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         load_err_q <= load_err_d;
      end
   end

   // Bypass is gated by rst_n so outputs stay 0 while reset is held.
   always_comb begin
      rd_a = '0;
      if (rs_a != 5'd0) begin
         if (w_bypass_en && load[rs_a]) begin
            rd_a = wr_data;
         end else begin
            rd_a = regs_q[rs_a];
         end
      end
   end

   always_comb begin
      rd_b = '0;
      if (rs_b != 5'd0) begin
         if (w_bypass_en && load[rs_b]) begin
            rd_b = wr_data;
         end else begin
            rd_b = regs_q[rs_b];
         end
      end
   end

   assign load_err = load_err_q;

endmodule

`default_nettype wire

// File: doc/reg_file_32x32.md
# reg_file_32x32

General-purpose register file for the datapath, sitting directly downstream of the 5-to-32 destination decoder. It consumes the decoder's one-hot 32-bit `load` vector as its write select and stores write-back data into the selected register. It provides two combinational read ports with same-cycle write-through bypass. It also checks the one-hot integrity of `load` and reports violations through a sticky error flag.

## Interface
Parameters:
- `DATA_W`, default 32: register and data width.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `load`, input, 32: one-hot write select from the destination decoder; bit i selects register i.
- `we`, input, 1: write strobe; `load` is ignored when low.
- `wr_data`, input, `DATA_W`: write-back data.
- `rs_a`, input, 5: read port A register index.
- `rs_b`, input, 5: read port B register index.
- `rd_a`, output, `DATA_W`: read port A data.
- `rd_b`, output, `DATA_W`: read port B data.
- `err_clr`, input, 1: synchronous clear of `load_err`.
- `load_err`, output, 1: sticky flag; set when a write is attempted with a non-one-hot `load`.

## Operation
- Storage is 32 registers × `DATA_W`. R0 is hardwired to zero: it always reads 0, and writes to it are discarded silently (not an error).
- Valid write: requires `we`=1 and `load` with exactly one bit set.
  - If that bit is i≠0, register i takes `wr_data` on the rising edge.
  - If i=0, nothing is written.
- Invalid write: `we`=1 with `load`=0 or with two or more bits set.
  - No register changes.
  - `load_err` goes to 1 at that edge.
- `we`=0: no write occurs and no error is raised, whatever `load` holds.
- `load_err` priority per edge: a set event wins over `err_clr`. Otherwise `err_clr`=1 clears the flag. Otherwise the flag holds.
- Reads are combinational from `rs_a`/`rs_b`:
  - If `rs`=0, the output is 0.
  - Else if a valid write targets the same index this cycle (`we`=1, `load` one-hot, `load[rs]`=1), the output is `wr_data` (write-through bypass).
  - Else the output is the stored register value.
- Both read ports are independent and may address the same register.
- Reset (`rst_n`=0, any time, including mid-write):
  - All registers clear to 0 immediately and `load_err` clears to 0.
  - A write coincident with reset is lost.
  - `rd_a`/`rd_b` read 0 for as long as reset is held, because all registers are 0 and bypass is suppressed.

## Timing
- Write latency: 1 cycle. Data presented at edge N is readable from storage after edge N, and is visible via bypass during the cycle before edge N.
- Read latency: 0 cycles (combinational from `rs_*`, `load`, `we`, `wr_data`).
- `load_err`: registered; asserts 1 cycle after the offending edge's inputs are sampled and stays high until cleared.
- Reset values: all registers 0, `load_err`=0. `rd_a`/`rd_b` are 0 under reset.
- Release of `rst_n` is synchronized externally. The first write is accepted at the first rising edge with `rst_n`=1.
- The one-hot check is a combinational popcount==1 test on `load`, gated by `we`. It must not add a pipeline stage.

## Test plan
- Reset then reads: hold `rst_n`=0 and sweep `rs_a`/`rs_b` over 0..31 → `rd_a`=`rd_b`=0 and `load_err`=0.
- Basic write/read: `we`=1, `load`=32'h0000_0020, `wr_data`=32'hDEAD_BEEF, one edge; then `rs_a`=5 → `rd_a`=32'hDEAD_BEEF, and all other registers remain 0.
- Bypass: with R7=32'h1111_1111, drive `we`=1, `load`=32'h0000_0080, `wr_data`=32'h2222_2222, `rs_b`=7 → `rd_b`=32'h2222_2222 before the edge and after it.
- R0 protection: `we`=1, `load`=32'h0000_0001, `wr_data`=32'hFFFF_FFFF → `rd_a`(`rs_a`=0)=0 both before and after the edge, and `load_err`=0.
- One-hot violation: `we`=1, `load`=32'h0000_0006, `wr_data`=32'hAAAA_AAAA → R1 and R2 unchanged and `load_err`=1 after the edge. Repeat with `load`=0 → same result. Then `err_clr`=1 with `we`=0 → `load_err`=0 after one edge. Then `err_clr`=1 together with a bad write → `load_err`=1.
- Reset mid-operation: after filling R1..R31 with their index, drive `rst_n`=0 asynchronously between edges while `we`=1 → all reads are 0 immediately, the pending write is lost, and `load_err`=0.
